// File: rtl/bcd_count_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_count_ctrl
//   Control and sequencing block for a 4-digit BCD counter datapath.
//   - Conditions three debounced button levels into single-cycle events
//     (2-FF synchronizer + registered rising-edge detector).
//   - A mode FSM (IDLE/RUN/PAUSE/HOLD) with a tick prescaler drives the
//     counter's enable, direction and clear strobes.
//   - A free-running scan counter time-shares the 4-digit display.
//
// Parameters:
//   TICK_DIV  clk cycles per count tick in RUN (min 2)
//   SCAN_DIV  clk cycles per display digit step (min 2)
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous reset, active-high
//   btn_run  in   run/pause button level (async to clk)
//   btn_clr  in   clear button level (async to clk)
//   btn_dir  in   direction button level (async to clk)
//   at_max   in   counter value is 9999
//   at_min   in   counter value is 0000
//   cnt_en   out  one-cycle count strobe
//   cnt_up   out  count direction, 1 = up
//   cnt_clr  out  one-cycle clear strobe
//   state_o  out  mode: 00 IDLE, 01 RUN, 10 PAUSE, 11 HOLD
//   dig_sel  out  digit index currently displayed
//   an       out  anode enables, active-low one-hot
//
// Build option:
//   BCD_COUNT_CTRL_WRAP_EN  when defined, a tick at the count limit still
//                           issues cnt_en (counter wraps) and HOLD is never
//                           entered; otherwise the FSM stops in HOLD.
// ---------------------------------------------------------------------------
module bcd_count_ctrl #(
   parameter int unsigned TICK_DIV = 50000000,
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_run,
   input  logic       btn_clr,
   input  logic       btn_dir,
   input  logic       at_max,
   input  logic       at_min,
   output logic       cnt_en,
   output logic       cnt_up,
   output logic       cnt_clr,
   output logic [1:0] state_o,
   output logic [1:0] dig_sel,
   output logic [3:0] an
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam int unsigned SW = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StRun   = 2'b01,
      StPause = 2'b10,
      StHold  = 2'b11
   } state_e;

   // ------------------------------------------------------------------------
   // Input conditioning, bit order {dir, clr, run}
   // ------------------------------------------------------------------------
   logic [2:0] btn_vec;
   logic [2:0] sync1_q, sync2_q, prev_q, ev_q;

   assign btn_vec = {btn_dir, btn_clr, btn_run};

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         ev_q    <= '0;
      end else begin
         sync1_q <= btn_vec;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         // Registered edge: event appears 3 cycles after the button edge
         ev_q    <= sync2_q & ~prev_q;
      end
   end

   logic run_ev, clr_ev, dir_ev;
   assign run_ev = ev_q[0];
   assign clr_ev = ev_q[1];
   assign dir_ev = ev_q[2];

   // ------------------------------------------------------------------------
   // Mode FSM and prescaler
   // ------------------------------------------------------------------------
   state_e        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          up_q, up_d;
   logic          en_q, en_d;
   logic          clr_q, clr_d;
   logic          tick;
   logic          limit;

   assign limit = (up_q & at_max) | (~up_q & at_min);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         presc_q <= '0;
         up_q    <= 1'b1;
         en_q    <= 1'b0;
         clr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         up_q    <= up_d;
         en_q    <= en_d;
         clr_q   <= clr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      up_d    = up_q;
      en_d    = 1'b0;
      clr_d   = 1'b0;
      tick    = 1'b0;

      if (clr_ev) begin
         // Clear wins over everything else in the same cycle
         state_d = StIdle;
         presc_d = '0;
         up_d    = 1'b1;
         clr_d   = 1'b1;
      end else begin
         // Direction is judged against the pre-transition state
         if (dir_ev && (state_q == StIdle || state_q == StPause)) begin
            up_d = ~up_q;
         end

         unique case (state_q)
            StIdle: begin
               if (run_ev) begin
                  state_d = StRun;
                  presc_d = '0;
               end
            end
            StRun: begin
               tick    = (presc_q == PRESC_MAX);
               presc_d = tick ? '0 : presc_q + 1'b1;
               // Leaving RUN drops any coincident tick so cnt_en stays
               // confined to RUN
               if (run_ev) begin
                  state_d = StPause;
               end else if (tick) begin
`ifdef BCD_COUNT_CTRL_WRAP_EN
                  en_d = 1'b1;
`else
                  if (limit) begin
                     state_d = StHold;
                  end else begin
                     en_d = 1'b1;
                  end
`endif
               end
            end
            StPause: begin
               // Prescaler keeps its frozen value across the pause
               if (run_ev) begin
                  state_d = StRun;
               end
            end
            StHold: begin
               // Only a clear event leaves HOLD
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   assign cnt_en  = en_q;
   assign cnt_up  = up_q;
   assign cnt_clr = clr_q;
   assign state_o = state_q;

   // ------------------------------------------------------------------------
   // Display scan, free-running in every mode
   // ------------------------------------------------------------------------
   logic [SW-1:0] scan_q;
   logic [1:0]    dig_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_q <= '0;
         dig_q  <= '0;
      end else if (scan_q == SCAN_MAX) begin
         scan_q <= '0;
         dig_q  <= dig_q + 2'd1;
      end else begin
         scan_q <= scan_q + 1'b1;
      end
   end

   assign dig_sel = dig_q;
   assign an      = ~(4'b0001 << dig_q);

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_count_ctrl
//   Bench for bcd_count_ctrl with TICK_DIV=4, SCAN_DIV=2. A cycle-level
//   reference model derived from the mode rules checks every cycle; a table
//   of hand-derived vectors covers reset, scan and the first run press;
//   directed sequences cover pause/resume, limit, clear priority and reset.
// ---------------------------------------------------------------------------
module tb_bcd_count_ctrl;

   localparam int unsigned TD = 4;
   localparam int unsigned SD = 2;

   logic       clk = 1'b0;
   logic       rst, btn_run, btn_clr, btn_dir, at_max, at_min;
   logic       cnt_en, cnt_up, cnt_clr;
   logic [1:0] state_o, dig_sel;
   logic [3:0] an;

   always #5 clk = ~clk;

   bcd_count_ctrl #(
      .TICK_DIV (TD),
      .SCAN_DIV (SD)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .btn_run (btn_run),
      .btn_clr (btn_clr),
      .btn_dir (btn_dir),
      .at_max  (at_max),
      .at_min  (at_min),
      .cnt_en  (cnt_en),
      .cnt_up  (cnt_up),
      .cnt_clr (cnt_clr),
      .state_o (state_o),
      .dig_sel (dig_sel),
      .an      (an)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // ------------------------------------------------------------------------
   // Reference model: mode 0 IDLE, 1 RUN, 2 PAUSE, 3 HOLD
   // ------------------------------------------------------------------------
   int       m_mode, m_presc, m_cycles;
   bit       m_up, m_en, m_clr;
   bit [3:0] h_run, h_clr, h_dir;   // bit i = button sample i+1 edges ago

   task automatic model_edge();
      bit er, ec, ed, tk, lim;
      if (rst) begin
         m_mode = 0; m_presc = 0; m_cycles = 0;
         m_up = 1'b1; m_en = 1'b0; m_clr = 1'b0;
         h_run = '0; h_clr = '0; h_dir = '0;
         return;
      end
      // A button rising edge becomes an event consumed 3 edges later
      er = h_run[2] & ~h_run[3];
      ec = h_clr[2] & ~h_clr[3];
      ed = h_dir[2] & ~h_dir[3];
      h_run = {h_run[2:0], btn_run};
      h_clr = {h_clr[2:0], btn_clr};
      h_dir = {h_dir[2:0], btn_dir};
      m_en  = 1'b0;
      m_clr = 1'b0;
      if (ec) begin
         m_mode = 0; m_presc = 0; m_up = 1'b1; m_clr = 1'b1;
      end else begin
         if (ed && (m_mode == 0 || m_mode == 2)) m_up = !m_up;
         case (m_mode)
            0: if (er) begin m_mode = 1; m_presc = 0; end
            1: begin
               tk = (m_presc == TD - 1);
               m_presc = (m_presc + 1) % TD;
               lim = m_up ? at_max : at_min;
               if (er) m_mode = 2;
               else if (tk) begin
`ifdef BCD_COUNT_CTRL_WRAP_EN
                  m_en = 1'b1;
`else
                  if (lim) m_mode = 3;
                  else m_en = 1'b1;
`endif
               end
            end
            2: if (er) m_mode = 1;
            default: ;
         endcase
      end
      m_cycles++;
   endtask

   function automatic logic [10:0] model_vec();
      int         d;
      logic [1:0] dd;
      logic [1:0] mm;
      d  = (m_cycles / SD) % 4;
      dd = d[1:0];
      mm = m_mode[1:0];
      return {mm, m_en, m_up, m_clr, dd, ~(4'b0001 << dd)};
   endfunction

   function automatic logic [10:0] dut_vec();
      return {state_o, cnt_en, cnt_up, cnt_clr, dig_sel, an};
   endfunction

   task automatic compare(input string name, input logic [10:0] got, input logic [10:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got state=%b en=%b up=%b clr=%b dig=%0d an=%b, expected state=%b en=%b up=%b clr=%b dig=%0d an=%b",
                  name, got[10:9], got[8], got[7], got[6], got[5:4], got[3:0],
                  exp[10:9], exp[8], exp[7], exp[6], exp[5:4], exp[3:0]);
      end
   endtask

   task automatic check_val(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // Inputs are already set (at a negedge); advance one edge and compare
   task automatic clk_step(input string name);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare(name, dut_vec(), model_vec());
   endtask

   task automatic do_reset();
      rst = 1'b1; btn_run = 1'b0; btn_clr = 1'b0; btn_dir = 1'b0;
      at_max = 1'b0; at_min = 1'b0;
      clk_step("reset");
      rst = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   // Vector table
   // ------------------------------------------------------------------------
   typedef struct {
      bit         rst, run, clr, dir, amax, amin;
      logic [1:0] e_state;
      bit         e_en, e_up, e_clr;
      logic [1:0] e_dig;
      logic [3:0] e_an;
   } vec_t;

   vec_t tbl[14];

   initial begin
      int  k;
      bit  saw_en, saw_clr_then_en;
      int  n_clr;

      // Reset, then run held high from the first cycle on
      tbl[0]  = '{1, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 2'd0, 4'b1110};
      tbl[1]  = '{0, 1, 0, 0, 0, 0, 2'b00, 0, 1, 0, 2'd0, 4'b1110};
      tbl[2]  = '{0, 1, 0, 0, 0, 0, 2'b00, 0, 1, 0, 2'd1, 4'b1101};
      tbl[3]  = '{0, 1, 0, 0, 0, 0, 2'b00, 0, 1, 0, 2'd1, 4'b1101};
      tbl[4]  = '{0, 1, 0, 0, 0, 0, 2'b01, 0, 1, 0, 2'd2, 4'b1011};
      tbl[5]  = '{0, 1, 0, 0, 0, 0, 2'b01, 0, 1, 0, 2'd2, 4'b1011};
      tbl[6]  = '{0, 1, 0, 0, 0, 0, 2'b01, 0, 1, 0, 2'd3, 4'b0111};
      tbl[7]  = '{0, 1, 0, 0, 0, 0, 2'b01, 0, 1, 0, 2'd3, 4'b0111};
      tbl[8]  = '{0, 1, 0, 0, 0, 0, 2'b01, 1, 1, 0, 2'd0, 4'b1110};
      tbl[9]  = '{0, 1, 0, 0, 0, 0, 2'b01, 0, 1, 0, 2'd0, 4'b1110};
      tbl[10] = '{0, 1, 0, 0, 0, 0, 2'b01, 0, 1, 0, 2'd1, 4'b1101};
      tbl[11] = '{0, 1, 0, 0, 0, 0, 2'b01, 0, 1, 0, 2'd1, 4'b1101};
      tbl[12] = '{0, 1, 0, 0, 0, 0, 2'b01, 1, 1, 0, 2'd2, 4'b1011};
      tbl[13] = '{0, 1, 0, 0, 0, 0, 2'b01, 0, 1, 0, 2'd2, 4'b1011};

      rst = 1'b1; btn_run = 1'b0; btn_clr = 1'b0; btn_dir = 1'b0;
      at_max = 1'b0; at_min = 1'b0;

      for (int i = 0; i < 14; i++) begin
         rst = tbl[i].rst; btn_run = tbl[i].run; btn_clr = tbl[i].clr;
         btn_dir = tbl[i].dir; at_max = tbl[i].amax; at_min = tbl[i].amin;
         clk_step($sformatf("model_tbl%0d", i));
         compare($sformatf("table_row%0d", i), dut_vec(),
                 {tbl[i].e_state, tbl[i].e_en, tbl[i].e_up, tbl[i].e_clr,
                  tbl[i].e_dig, tbl[i].e_an});
      end

      // Held run level: no further event, so still RUN after a long hold
      for (int i = 0; i < 10; i++) clk_step("run_held");
      check_val("run_held_state", int'(state_o), 1);

      // ---- Pause with prescaler at 2, flip direction, resume -------------
      do_reset();
      btn_run = 1'b1; clk_step("pause_a");
      btn_run = 1'b0; clk_step("pause_b");
      btn_run = 1'b1; clk_step("pause_c");
      btn_run = 1'b0;
      for (int i = 0; i < 3; i++) clk_step("pause_d");
      check_val("pause_state", int'(state_o), 2);
      check_val("pause_presc_model", m_presc, 2);
      btn_dir = 1'b1;
      for (int i = 0; i < 4; i++) clk_step("dir_press");
      btn_dir = 1'b0;
      check_val("dir_in_pause", int'(cnt_up), 0);
      clk_step("dir_rel");
      btn_run = 1'b1;
      k = 0;
      while (state_o !== 2'b01 && k < 10) begin clk_step("resume_wait"); k++; end
      check_val("resume_reached", int'(state_o === 2'b01), 1);
      k = 0;
      while (cnt_en !== 1'b1 && k < 10) begin clk_step("resume_tick"); k++; end
      check_val("resume_first_en_delay", k, 2);
      check_val("up_kept_in_run", int'(cnt_up), 0);
      btn_run = 1'b0;
      clk_step("resume_rel");

      // ---- Tick at the limit --------------------------------------------
      do_reset();
      at_max = 1'b1;
      btn_run = 1'b1;
      saw_en = 1'b0;
      for (int i = 0; i < 12; i++) begin
         clk_step("limit_run");
         if (cnt_en === 1'b1) saw_en = 1'b1;
      end
      btn_run = 1'b0;
`ifdef BCD_COUNT_CTRL_WRAP_EN
      check_val("limit_wrap_state", int'(state_o), 1);
      check_val("limit_wrap_en", int'(saw_en), 1);
`else
      check_val("limit_hold_state", int'(state_o), 3);
      check_val("limit_no_en", int'(saw_en), 0);
      clk_step("limit_rel");
      btn_run = 1'b1;
      for (int i = 0; i < 8; i++) clk_step("hold_run_press");
      btn_run = 1'b0;
      check_val("hold_ignores_run", int'(state_o), 3);
`endif
      at_max = 1'b0;

      // ---- Clear and run edges together while running down --------------
      do_reset();
      btn_dir = 1'b1;
      for (int i = 0; i < 4; i++) clk_step("clr_dir");
      btn_dir = 1'b0;
      check_val("clr_pre_up", int'(cnt_up), 0);
      btn_run = 1'b1;
      for (int i = 0; i < 5; i++) clk_step("clr_run");
      btn_run = 1'b0;
      check_val("clr_pre_state", int'(state_o), 1);
      clk_step("clr_gap");
      btn_run = 1'b1; btn_clr = 1'b1;
      n_clr = 0;
      saw_clr_then_en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         clk_step("clr_both");
         if (cnt_clr === 1'b1) begin
            n_clr++;
            check_val("clr_pulse_state", int'(state_o), 0);
            check_val("clr_pulse_up", int'(cnt_up), 1);
            check_val("clr_pulse_no_en", int'(cnt_en), 0);
         end
         if (n_clr > 0 && cnt_en === 1'b1) saw_clr_then_en = 1'b1;
      end
      btn_run = 1'b0; btn_clr = 1'b0;
      check_val("clr_pulse_count", n_clr, 1);
      check_val("clr_no_en_after", int'(saw_clr_then_en), 0);
      check_val("clr_final_state", int'(state_o), 0);

      // ---- Reset landing on a tick cycle --------------------------------
      do_reset();
      btn_run = 1'b1;
      k = 0;
      while (!(m_mode == 1 && m_presc == TD - 1) && k < 20) begin
         clk_step("rst_run"); k++;
      end
      check_val("rst_tick_reached", int'(m_mode == 1 && m_presc == TD - 1), 1);
      btn_run = 1'b0;
      rst = 1'b1;
      clk_step("rst_mid");
      rst = 1'b0;
      compare("rst_mid_values", dut_vec(), {2'b00, 1'b0, 1'b1, 1'b0, 2'd0, 4'b1110});
      clk_step("rst_after");
      check_val("rst_no_en", int'(cnt_en), 0);

      // ---- Randomised run against the model -----------------------------
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 11) == 0) btn_run = ~btn_run;
         if ($urandom_range(0, 59) == 0) btn_clr = ~btn_clr;
         if ($urandom_range(0, 15) == 0) btn_dir = ~btn_dir;
         at_max = ($urandom_range(0, 3) == 0);
         at_min = ($urandom_range(0, 3) == 0);
         rst    = ($urandom_range(0, 399) == 0);
         clk_step("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_count_ctrl.md
Name: bcd_count_ctrl

Overview:
- Control and sequencing block for the 4-digit BCD counter datapath.
- Takes debounced button levels (run/pause, clear, direction) and turns them into single-cycle events.
- A mode FSM plus a tick prescaler drives the counter's enable, direction and clear, and stops at the count limits.
- Also time-shares the 4-digit display by scanning the digit select and anode lines.

Parameters:
- TICK_DIV, 50000000: clk cycles per count tick in RUN (min 2).
- SCAN_DIV, 50000: clk cycles per display digit step (min 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- btn_run  in  1  debounced run/pause button level, asynchronous to clk.
- btn_clr  in  1  debounced clear button level, asynchronous to clk.
- btn_dir  in  1  debounced direction button level, asynchronous to clk.
- at_max  in  1  counter value is 9999.
- at_min  in  1  counter value is 0000.
- cnt_en  out  1  one-cycle count strobe to the counter.
- cnt_up  out  1  count direction: 1 = up, 0 = down.
- cnt_clr  out  1  one-cycle clear strobe to the counter.
- state_o  out  2  current mode: 00 IDLE, 01 RUN, 10 PAUSE, 11 HOLD.
- dig_sel  out  2  digit index currently displayed.
- an  out  4  anode enables, active-low, one-hot.

Behaviour:
- Reset: synchronous on rising clk with rst=1. Reset values:
  - state IDLE; cnt_en=0; cnt_clr=0; cnt_up=1.
  - Prescaler=0; scan counter=0; dig_sel=0; an=4'b1110.
  - Sync and edge registers = 0.
  - Reset mid-run abandons all activity; no strobe is emitted in the reset cycle.
- Input conditioning:
  - Each button passes through a 2-FF synchronizer, then a rising-edge detector.
  - This gives a 1-cycle event: run_ev, clr_ev, dir_ev.
  - Latency from button edge to event = 3 clk cycles.
  - A held level produces exactly one event.
- Priority in a single cycle: clr_ev > run_ev / dir_ev.
  - With clr_ev set, the other events are discarded.
  - run_ev and dir_ev in the same cycle: dir is evaluated against the current (pre-transition) state, then the run transition applies.
- FSM transitions (registered; state_o changes the cycle after the event):
  - Any state + clr_ev -> IDLE. Effects: cnt_clr=1 for one cycle, prescaler=0, cnt_up=1.
  - IDLE + run_ev -> RUN. Prescaler restarts at 0.
  - RUN + run_ev -> PAUSE. Prescaler is frozen (keeps its value).
  - PAUSE + run_ev -> RUN. Prescaler resumes from the frozen value.
  - HOLD + run_ev -> ignored; only clr_ev exits HOLD.
  - dir_ev toggles cnt_up only in IDLE or PAUSE; it is ignored in RUN and HOLD.
- Prescaler: increments each cycle in RUN only.
  - At value TICK_DIV-1 it wraps to 0 and generates a tick.
  - First tick after IDLE->RUN comes TICK_DIV cycles after state_o becomes RUN.
- Tick handling in RUN:
  - Not at limit: cnt_en=1 for exactly one cycle, registered in the cycle after the tick.
  - Limit condition = (cnt_up & at_max) | (~cnt_up & at_min).
  - At limit (default build): no cnt_en is issued, and state -> HOLD.
  - Limit inputs are sampled at the tick cycle only.
- cnt_en is never asserted outside RUN, and never in the same cycle as cnt_clr.
- Display scan:
  - Free-running in all states, including reset release; unaffected by clr_ev.
  - Scan counter counts 0..SCAN_DIV-1; on wrap, dig_sel increments modulo 4 (3 -> 0).
  - an = ~(4'b0001 << dig_sel), updated in the same cycle as dig_sel.
- Widths: prescaler width = clog2(TICK_DIV); scan counter width = clog2(SCAN_DIV).

Optional Feature:
- Macro: BCD_COUNT_CTRL_WRAP_EN.
- Defined:
  - At the limit tick, cnt_en is still issued; the counter wraps 9999->0000 or 0000->9999.
  - State stays RUN; the HOLD state is unreachable.
- Not defined: stop-at-limit behaviour into HOLD, as described above.

Test Plan (TICK_DIV=4, SCAN_DIV=2):
- Reset then release: state_o=00, cnt_up=1, an=1110 -> dig_sel sequence 0,1,2,3,0 advancing every 2 cycles, an following 1110,1101,1011,0111.
- run press, hold high 20 cycles -> state_o=01 at cycle 4 after the edge; cnt_en pulses every 4 cycles, each 1 cycle wide; no second run event while held.
- run, run -> PAUSE with prescaler at 2 -> dir press -> cnt_up=0 -> run -> first cnt_en 2 cycles after RUN resumes.
- RUN, cnt_up=1, at_max=1 at tick:
  - Default build: no cnt_en, state_o=11; a further run press is ignored.
  - With BCD_COUNT_CTRL_WRAP_EN: cnt_en=1 and state_o stays 01.
- clr and run edges in the same cycle while in RUN, cnt_up=0 -> state_o=00, single cnt_clr pulse, cnt_up=1, no cnt_en.
- rst asserted for one cycle mid-RUN, 1 cycle before a tick -> no cnt_en; all outputs at reset values in the following cycle.
